// File: rtl/nco_iq2phase_cordic.sv
// rtl/nco_iq2phase_cordic.sv - iterative vectoring CORDIC: signed I/Q sample to NCO-scale phase and magnitude
module nco_iq2phase_cordic #(
    parameter int mpr   = 17,
    parameter int apr   = 32,
    parameter int niter = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clken,
    input  logic [mpr-1:0]   fsin_i,
    input  logic [mpr-1:0]   fcos_i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [apr-1:0]   phase_o,
    output logic [mpr+1:0]   mag_o,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int W  = mpr + 3;
    localparam int CW = $clog2(niter);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [W-1:0]   x_q, x_d, y_q, y_d;
    logic [apr-1:0]        z_q, z_d;
    logic                  zero_q, zero_d;
    logic [apr-1:0]        phase_q, phase_d;
    logic [mpr+1:0]        mag_q, mag_d;

    logic signed [W-1:0]   cos_ext, sin_ext;
    logic signed [W-1:0]   x_sh, y_sh, x_rot, y_rot;
    logic [apr-1:0]        z_rot, a_i;
    logic [31:0]           a_full;

    // round(atan(2^-i) / (2*pi) * 2^32); narrower phase widths keep the top apr bits
    function automatic logic [31:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:  atan_lut = 32'h2000_0000;
            5'd1:  atan_lut = 32'h12E4_051E;
            5'd2:  atan_lut = 32'h09FB_385B;
            5'd3:  atan_lut = 32'h0511_11D4;
            5'd4:  atan_lut = 32'h028B_0D43;
            5'd5:  atan_lut = 32'h0145_D7E1;
            5'd6:  atan_lut = 32'h00A2_F61E;
            5'd7:  atan_lut = 32'h0051_7C55;
            5'd8:  atan_lut = 32'h0028_BE53;
            5'd9:  atan_lut = 32'h0014_5F2F;
            5'd10: atan_lut = 32'h000A_2F98;
            5'd11: atan_lut = 32'h0005_17CC;
            5'd12: atan_lut = 32'h0002_8BE6;
            5'd13: atan_lut = 32'h0001_45F3;
            5'd14: atan_lut = 32'h0000_A2FA;
            5'd15: atan_lut = 32'h0000_517D;
            5'd16: atan_lut = 32'h0000_28BE;
            5'd17: atan_lut = 32'h0000_145F;
            5'd18: atan_lut = 32'h0000_0A30;
            5'd19: atan_lut = 32'h0000_0518;
            5'd20: atan_lut = 32'h0000_028C;
            5'd21: atan_lut = 32'h0000_0146;
            5'd22: atan_lut = 32'h0000_00A3;
            5'd23: atan_lut = 32'h0000_0051;
            5'd24: atan_lut = 32'h0000_0029;
            5'd25: atan_lut = 32'h0000_0014;
            5'd26: atan_lut = 32'h0000_000A;
            5'd27: atan_lut = 32'h0000_0005;
            5'd28: atan_lut = 32'h0000_0003;
            5'd29: atan_lut = 32'h0000_0001;
            5'd30: atan_lut = 32'h0000_0001;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    assign cos_ext = {{3{fcos_i[mpr-1]}}, fcos_i};
    assign sin_ext = {{3{fsin_i[mpr-1]}}, fsin_i};

    assign a_full = atan_lut(5'(cnt_q));
    assign a_i    = a_full[31 -: apr];

    // One micro-rotation, driving Y toward zero; both shifts use the pre-update X/Y
    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        if (!y_q[W-1]) begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + a_i;
        end else begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - a_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        phase_d = phase_q;
        mag_d   = mag_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Left half-plane is folded into the right half by a 180 degree pre-rotation
                    if (fcos_i[mpr-1]) begin
                        x_d = -cos_ext;
                        y_d = -sin_ext;
                        z_d = {1'b1, {(apr-1){1'b0}}};
                    end else begin
                        x_d = cos_ext;
                        y_d = sin_ext;
                        z_d = '0;
                    end
                    zero_d  = (fcos_i == '0) && (fsin_i == '0);
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (cnt_q == CW'(niter - 1)) begin
                    phase_d = zero_q ? '0 : z_rot;
                    mag_d   = zero_q ? '0 : x_rot[mpr+1:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            phase_q <= '0;
            mag_q   <= '0;
        end else if (clken) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            phase_q <= phase_d;
            mag_q   <= mag_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign phase_o   = phase_q;
    assign mag_o     = mag_q;

endmodule

// File: tb/tb_nco_iq2phase_cordic.sv
// tb/tb_nco_iq2phase_cordic.sv - directed-vector bench for nco_iq2phase_cordic
module tb_nco_iq2phase_cordic;

    localparam int MPR      = 17;
    localparam int APR      = 32;
    localparam int NITER    = 16;
    localparam int PH_TOL   = 65536;
    localparam int MAG_TOL  = 8;
    localparam int BUDGET   = 200;

    logic              clk = 1'b0;
    logic              reset;
    logic              clken;
    logic [MPR-1:0]    fsin_i;
    logic [MPR-1:0]    fcos_i;
    logic              in_valid;
    logic              in_ready;
    logic [APR-1:0]    phase_o;
    logic [MPR+1:0]    mag_o;
    logic              out_valid;
    logic              out_ready;

    int checks   = 0;
    int failures = 0;

    nco_iq2phase_cordic #(.mpr(MPR), .apr(APR), .niter(NITER)) dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .fsin_i    (fsin_i),
        .fcos_i    (fcos_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .phase_o   (phase_o),
        .mag_o     (mag_o),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int ph_err(input logic [31:0] got, input logic [31:0] want);
        logic signed [31:0] d;
        d = got - want;
        return (d < 0) ? -int'(d) : int'(d);
    endfunction

    function automatic int mag_err(input logic [MPR+1:0] got, input int want);
        int d;
        d = int'(got) - want;
        return (d < 0) ? -d : d;
    endfunction

    // Presents one sample from a negedge and waits for the result; assumes the block is idle
    task automatic send(input int c, input int s, output int cyc,
                        output logic [31:0] ph, output logic [MPR+1:0] mg, output bit to);
        to  = 1'b0;
        cyc = 0;
        @(negedge clk);
        fcos_i   = MPR'(c);
        fsin_i   = MPR'(s);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && cyc < BUDGET) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        to = !out_valid;
        ph = phase_o;
        mg = mag_o;
    endtask

    task automatic test_reset;
        reset = 1'b1; clken = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        fcos_i = '0; fsin_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (phase_o !== '0) begin failures++; $display("FAIL reset_phase got %h want 0", phase_o); end
        checks++; if (mag_o !== '0) begin failures++; $display("FAIL reset_mag got %0d want 0", mag_o); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_first_sample;
        int cyc;
        cyc = 0;
        @(negedge clk);
        fcos_i = MPR'(16384); fsin_i = '0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL first_in_ready_drop got %b want 0", in_ready); end
        while (!out_valid && cyc < BUDGET) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        checks++; if (cyc !== NITER) begin failures++; $display("FAIL first_latency got %0d want %0d", cyc, NITER); end
        checks++; if (ph_err(phase_o, 32'h0) > PH_TOL) begin failures++; $display("FAIL first_phase got %h want 00000000", phase_o); end
        checks++; if (mag_err(mag_o, 26981) > MAG_TOL) begin failures++; $display("FAIL first_mag got %0d want 26981", mag_o); end
    endtask

    task automatic test_quadrants;
        int          cv [4] = '{0, -16384, 0, -65536};
        int          sv [4] = '{16384, 0, -16384, -65536};
        logic [31:0] ep [4] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'hA000_0000};
        int          em [4] = '{26981, 26981, 26981, 152631};
        int cyc; logic [31:0] ph; logic [MPR+1:0] mg; bit to;
        for (int i = 0; i < 4; i++) begin
            send(cv[i], sv[i], cyc, ph, mg, to);
            checks++; if (to) begin failures++; $display("FAIL quad%0d_timeout got no out_valid want out_valid", i); end
            checks++; if (cyc !== NITER) begin failures++; $display("FAIL quad%0d_latency got %0d want %0d", i, cyc, NITER); end
            checks++; if (ph_err(ph, ep[i]) > PH_TOL) begin failures++; $display("FAIL quad%0d_phase got %h want %h", i, ph, ep[i]); end
            checks++; if (mag_err(mg, em[i]) > MAG_TOL) begin failures++; $display("FAIL quad%0d_mag got %0d want %0d", i, mg, em[i]); end
        end
    endtask

    task automatic test_zero_extremes;
        int cyc; logic [31:0] ph; logic [MPR+1:0] mg; bit to;
        send(0, 0, cyc, ph, mg, to);
        checks++; if (to || ph !== 32'h0) begin failures++; $display("FAIL zero_phase got %h want 00000000", ph); end
        checks++; if (mg !== '0) begin failures++; $display("FAIL zero_mag got %0d want 0", mg); end
        send(-65536, 0, cyc, ph, mg, to);
        checks++; if (to || ph_err(ph, 32'h8000_0000) > PH_TOL) begin failures++; $display("FAIL negmax_phase got %h want 80000000", ph); end
        checks++; if (mag_err(mg, 107922) > MAG_TOL) begin failures++; $display("FAIL negmax_mag got %0d want 107922", mg); end
    endtask

    task automatic test_backpressure_clken;
        int n; int bad_hold; logic [31:0] ph; logic [MPR+1:0] mg;
        // clken low in IDLE must block the accept
        @(negedge clk);
        out_ready = 1'b0;
        fcos_i = MPR'(16384); fsin_i = MPR'(16384); in_valid = 1'b1; clken = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL clken_idle_hold got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        clken = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fcos_i = MPR'(-300); fsin_i = MPR'(777);
        n = 0;
        while (!out_valid && n < BUDGET) begin
            n++;
            clken = (n >= 4 && n <= 6) ? 1'b0 : 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        clken = 1'b1;
        checks++; if (n !== NITER + 3) begin failures++; $display("FAIL clken_latency got %0d want %0d", n, NITER + 3); end
        ph = phase_o; mg = mag_o;
        checks++; if (ph_err(ph, 32'h2000_0000) > PH_TOL) begin failures++; $display("FAIL bp_phase got %h want 20000000", ph); end
        checks++; if (mag_err(mg, 38156) > MAG_TOL) begin failures++; $display("FAIL bp_mag got %0d want 38156", mg); end
        bad_hold = 0;
        for (int i = 0; i < 10; i++) begin
            fcos_i = MPR'(i * 1000); fsin_i = MPR'(-i * 500);
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || phase_o !== ph || mag_o !== mg) bad_hold++;
        end
        checks++; if (bad_hold !== 0) begin failures++; $display("FAIL backpressure_hold got %0d unstable cycles want 0", bad_hold); end
        out_ready = 1'b1; clken = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clken_done_hold got out_valid=%b want 1", out_valid); end
        clken = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL deliver got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_loopback;
        logic [31:0] acc; logic [31:0] res [5]; int got; int cyc; real th; int ic, is;
        logic [31:0] step;
        acc = 32'h0; got = 0; cyc = 0;
        step = 32'h0100_0000 * (NITER + 2);
        out_ready = 1'b1;
        while (got < 5 && cyc < 5 * BUDGET) begin
            @(negedge clk);
            if (out_valid) begin res[got] = phase_o; got++; end
            th = 2.0 * 3.141592653589793 * real'(acc) / 4294967296.0;
            ic = int'(32767.0 * $cos(th));
            is = int'(32767.0 * $sin(th));
            fcos_i = MPR'(ic); fsin_i = MPR'(is); in_valid = 1'b1;
            @(posedge clk);
            acc = acc + 32'h0100_0000;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (got !== 5) begin failures++; $display("FAIL loopback_count got %0d want 5", got); end
        for (int i = 1; i < got; i++) begin
            checks++;
            if (ph_err(res[i] - res[i-1], step) > 2 * PH_TOL) begin
                failures++; $display("FAIL loopback_delta%0d got %h want %h", i, res[i] - res[i-1], step);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_iter;
        int cyc; logic [31:0] ph; logic [MPR+1:0] mg; bit to;
        @(negedge clk);
        fcos_i = MPR'(16384); fsin_i = MPR'(16384); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL midreset_flags got out_valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
        checks++; if (phase_o !== '0 || mag_o !== '0) begin failures++; $display("FAIL midreset_outputs got %h/%0d want 0/0", phase_o, mag_o); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_release got %b want 1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_result got %b want 0", out_valid); end
        send(0, -16384, cyc, ph, mg, to);
        checks++; if (to || cyc !== NITER) begin failures++; $display("FAIL postreset_latency got %0d want %0d", cyc, NITER); end
        checks++; if (ph_err(ph, 32'hC000_0000) > PH_TOL) begin failures++; $display("FAIL postreset_phase got %h want c0000000", ph); end
        checks++; if (mag_err(mg, 26981) > MAG_TOL) begin failures++; $display("FAIL postreset_mag got %0d want 26981", mg); end
    endtask

    initial begin
        test_reset;
        test_first_sample;
        test_quadrants;
        test_zero_extremes;
        test_backpressure_clken;
        test_loopback;
        test_reset_mid_iter;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
